// File: rtl/step_clock_ctrl.sv
// Clock-enable generator: selectable tick rate, halt/run/step/burst modes, button debouncer,
// tick counter. Define STEP_CLOCK_HEARTBEAT_EN to add a heartbeat flop that toggles per tick.
module step_clock_ctrl #(
  parameter int unsigned CNT_W     = 23,
  parameter int unsigned DIV_BASE  = 5000000,
  parameter int unsigned DB_CYCLES = 500000,
  parameter int unsigned DB_W      = 19,
  parameter int unsigned BURST_LEN = 8,
  parameter int unsigned TCNT_W    = 8
) (
  input  logic              fastclk,
  input  logic              nReset,
  input  logic [1:0]        mode,
  input  logic [1:0]        rate,
  input  logic              btn_raw,
  output logic              tick,
  output logic [TCNT_W-1:0] tick_count,
  output logic              busy,
  output logic              btn_db,
  output logic              heartbeat
);

  localparam logic [1:0] ModeRun   = 2'b01;
  localparam logic [1:0] ModeStep  = 2'b10;
  localparam logic [1:0] ModeBurst = 2'b11;
  localparam int unsigned BurstW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] DivBase = CNT_W'(DIV_BASE);

  typedef enum logic [1:0] {StIdle, StRun, StBurst} state_e;

  logic              r_sync1, r_sync2, r_btn_db, r_press;
  logic [DB_W-1:0]   r_db_cnt;
  logic              w_db_diff, w_db_flip;

  logic [CNT_W-1:0]  r_div, w_div_d, w_shifted, w_period, w_div_inc;
  logic              w_div_term;
  logic [1:0]        r_mode, r_rate;
  logic              w_change;

  state_e            r_state, w_state_d;
  logic [BurstW-1:0] r_burst_cnt, w_burst_d;
  logic              r_tick, w_tick_d;
  logic              r_busy, w_busy_d;
  logic [TCNT_W-1:0] r_tick_count;

  // Debouncer: flip only after DB_CYCLES consecutive disagreeing samples.
  assign w_db_diff = (r_sync2 != r_btn_db);
  assign w_db_flip = w_db_diff && (r_db_cnt == DB_W'(DB_CYCLES - 1));

  always_ff @(posedge fastclk) begin
    if (!nReset) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_db_cnt <= '0;
      r_btn_db <= 1'b0;
      r_press  <= 1'b0;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
      if (!w_db_diff || w_db_flip) begin
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + DB_W'(1);
      end
      if (w_db_flip) begin
        r_btn_db <= ~r_btn_db;
      end
      r_press <= w_db_flip && !r_btn_db;
    end
  end

  assign w_shifted  = DivBase >> {rate, 1'b0};
  assign w_period   = (w_shifted == '0) ? CNT_W'(1) : w_shifted;
  assign w_div_term = (r_div == (w_period - CNT_W'(1)));
  assign w_div_inc  = w_div_term ? '0 : (r_div + CNT_W'(1));
  assign w_change   = (mode != r_mode) || (rate != r_rate);

  always_comb begin
    w_state_d = r_state;
    w_div_d   = '0;
    w_burst_d = r_burst_cnt;
    w_tick_d  = 1'b0;
    w_busy_d  = 1'b0;
    if (w_change) begin
      w_state_d = StIdle;
      w_burst_d = '0;
    end else begin
      case (r_state)
        StIdle: begin
          w_burst_d = '0;
          // RUN starts counting in the entry cycle so the first tick lands P cycles later.
          case (mode)
            ModeRun: begin
              w_state_d = StRun;
              w_div_d   = w_div_inc;
              w_tick_d  = w_div_term;
            end
            ModeStep:  w_tick_d = r_press;
            ModeBurst: begin
              if (r_press) begin
                w_state_d = StBurst;
                w_busy_d  = 1'b1;
              end
            end
            default: w_tick_d = 1'b0;
          endcase
        end
        StRun: begin
          w_div_d  = w_div_inc;
          w_tick_d = w_div_term;
        end
        StBurst: begin
          w_div_d  = w_div_inc;
          w_busy_d = 1'b1;
          if (w_div_term) begin
            w_tick_d = 1'b1;
            if (r_burst_cnt == BurstW'(BURST_LEN - 1)) begin
              w_state_d = StIdle;
              w_burst_d = '0;
            end else begin
              w_burst_d = r_burst_cnt + BurstW'(1);
            end
          end
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge fastclk) begin
    if (!nReset) begin
      r_state      <= StIdle;
      r_div        <= '0;
      r_burst_cnt  <= '0;
      r_tick       <= 1'b0;
      r_busy       <= 1'b0;
      r_tick_count <= '0;
      // Capture current settings so leaving reset is not seen as a change.
      r_mode       <= mode;
      r_rate       <= rate;
    end else begin
      r_state      <= w_state_d;
      r_div        <= w_div_d;
      r_burst_cnt  <= w_burst_d;
      r_tick       <= w_tick_d;
      r_busy       <= w_busy_d;
      r_tick_count <= r_tick_count + TCNT_W'(w_tick_d);
      r_mode       <= mode;
      r_rate       <= rate;
    end
  end

`ifdef STEP_CLOCK_HEARTBEAT_EN
  logic r_heartbeat;
  always_ff @(posedge fastclk) begin
    if (!nReset) begin
      r_heartbeat <= 1'b0;
    end else if (w_tick_d) begin
      r_heartbeat <= ~r_heartbeat;
    end
  end
  assign heartbeat = r_heartbeat;
`else
  assign heartbeat = 1'b0;
`endif

  assign tick       = r_tick;
  assign tick_count = r_tick_count;
  assign busy       = r_busy;
  assign btn_db     = r_btn_db;

endmodule

// File: doc/step_clock_ctrl.md
Name: step_clock_ctrl

Overview:
- Parametrised clock-enable generator for the picoMIPS DE0 demo harness. Successor to the fixed slow-clock divider.
- Runs on the 50 MHz board clock and drives a one-cycle `tick` enable into the processor. The processor then runs on `fastclk` with `tick` as its enable, with no derived clock.
- Adds selectable rates, halt/run/single-step/burst modes, an on-chip button debouncer and a tick counter for LED display.

Parameters:
- CNT_W, 23: width of the divider counter.
- DIV_BASE, 5000000: slowest tick period in fastclk cycles (10 Hz at 50 MHz); must fit in CNT_W.
- DB_CYCLES, 500000: consecutive stable cycles required before the debounced button changes (10 ms).
- DB_W, 19: width of the debounce counter.
- BURST_LEN, 8: number of ticks issued per burst; must be at least 1.
- TCNT_W, 8: width of `tick_count`.

Ports:
- fastclk, in, 1: board clock; all logic on its rising edge.
- nReset, in, 1: synchronous, active-low reset.
- mode, in, 2: 00 HALT, 01 RUN, 10 STEP, 11 BURST.
- rate, in, 2: period = DIV_BASE >> (2*rate); a computed period of 0 is treated as 1.
- btn_raw, in, 1: asynchronous push button, active-high.
- tick, out, 1: one-cycle clock-enable pulse.
- tick_count, out, TCNT_W: ticks issued since reset; wraps modulo 2^TCNT_W.
- busy, out, 1: high while a burst is in progress.
- btn_db, out, 1: debounced button level.
- heartbeat, out, 1: see Optional Feature.

Behaviour:
- Reset (nReset=0 at a rising edge):
  - Outputs: tick=0, tick_count=0, busy=0, btn_db=0, heartbeat=0.
  - Internal: divider=0, synchroniser flops=0, debounce counter=0, state=IDLE.
  - Reset asserted mid-burst or mid-period aborts immediately; no tick is issued in the reset cycle.
- Button path:
  - 2-flop synchroniser feeds the debouncer.
  - btn_db toggles once the synchronised input has differed from btn_db for DB_CYCLES consecutive cycles.
  - Any cycle where they agree clears the debounce counter.
  - A press event is a registered 0->1 transition of btn_db.
  - Latency from a clean btn_raw edge to the press event is 2 + DB_CYCLES cycles.
- Divider:
  - Counts 0..P-1, where P is the period selected by `rate`.
  - The terminal count P-1 yields a period event, and the divider returns to 0.
  - The divider is held at 0 while in IDLE.
- States:
  - IDLE (HALT or STEP with no pending event): divider held at 0.
  - RUN (mode=01): tick on every period event. The first tick comes P cycles after entering RUN.
  - BURST: entered from IDLE when mode=11 and a press event occurs; busy=1.
    - Issues a tick on each period event and counts ticks issued.
    - After the BURST_LEN-th tick: returns to IDLE, busy=0 on the following cycle.
    - Press events during a burst are ignored.
- STEP (mode=10): each press event produces tick exactly 1 cycle later. The divider is not used.
- HALT: tick is never asserted; press events are ignored.
- Mode or rate change:
  - Any change of `mode` or `rate` (registered compare) clears the divider and aborts a burst (busy=0).
  - No tick is issued in the change cycle.
  - The new settings take effect on the next cycle.
- Counter and pulse rules:
  - tick_count increments in the same cycle tick=1; it wraps from 2^TCNT_W-1 to 0.
  - tick is never high on two consecutive cycles unless P=1 in RUN, where it is continuously high.

Optional Feature:
- Macro: STEP_CLOCK_HEARTBEAT_EN.
- Defined: heartbeat toggles on every tick, giving a visible 50%-duty LED at tick/2.
- Undefined: heartbeat is tied to 0 and no flop is synthesised.

Test Plan:
- Common bench parameters: DIV_BASE=64, DB_CYCLES=4, BURST_LEN=3, TCNT_W=4.
- RUN period: hold nReset=0 for 2 cycles, then release with mode=01, rate=00 -> first tick at cycle 64 after release, then every 64 cycles. With rate=01, period is 16 cycles; with rate=11, period is 1 and tick stays high. tick_count increments per tick.
- STEP and bounce rejection: mode=10, btn_raw pulses 1 for 3 cycles, then 0 -> no tick. Then btn_raw held 1 -> exactly one tick at cycle 2+4+1 after the edge. Holding the button issues no further ticks.
- BURST: mode=11, rate=10 (P=4), one clean press -> busy rises, 3 ticks 4 cycles apart, busy falls 1 cycle after the third tick. A second press mid-burst does not extend it.
- Mode change mid-burst: mode 11 -> 00 after the first burst tick -> busy=0 next cycle, no further ticks, tick_count=1.
- Wrap and reset: 17 ticks in RUN -> tick_count=1. nReset=0 mid-period -> all outputs 0 next cycle, and the first tick after release comes a full period later.
